// File: rtl/rob.sv
// Reorder buffer: in-order allocate/retire, out-of-order CDB writeback,
// two combinational tag-lookup ports with CDB bypass for operand forwarding.
//
// Ports:
//   clk_i, rst_n_i (sync, active low), flush_i
//   issue_*  : allocation handshake, returns tag (= tail)
//   cdb_*    : result broadcast (tag, data, exception)
//   rs1_/rs2_: operand lookup (ready/value), bypassed from CDB
//   commit_* : head retire handshake with pc/rd/data/except
module rob #(
  parameter int DEPTH       = 16,
  parameter int XLEN        = 64,
  parameter int DATA_W      = XLEN,
  parameter int REG_IDX_LEN = 5,
  localparam int TAG_W      = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,

  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [XLEN-1:0]        issue_pc_i,
  input  logic [REG_IDX_LEN-1:0] issue_rd_idx_i,
  output logic [TAG_W-1:0]       issue_tag_o,

  input  logic                   cdb_valid_i,
  input  logic [TAG_W-1:0]       cdb_tag_i,
  input  logic [DATA_W-1:0]      cdb_data_i,
  input  logic                   cdb_except_i,

  input  logic [TAG_W-1:0]       rs1_tag_i,
  output logic                   rs1_ready_o,
  output logic [DATA_W-1:0]      rs1_value_o,
  input  logic [TAG_W-1:0]       rs2_tag_i,
  output logic                   rs2_ready_o,
  output logic [DATA_W-1:0]      rs2_value_o,

  output logic                   commit_valid_o,
  input  logic                   commit_ready_i,
  output logic [XLEN-1:0]        commit_pc_o,
  output logic [REG_IDX_LEN-1:0] commit_rd_idx_o,
  output logic [DATA_W-1:0]      commit_data_o,
  output logic                   commit_except_o
);

  localparam int CNT_W = TAG_W + 1;

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0]             done_q;
  logic [DEPTH-1:0]             except_q;
  logic [XLEN-1:0]              pc_q   [DEPTH];
  logic [REG_IDX_LEN-1:0]       rd_q   [DEPTH];
  logic [DATA_W-1:0]            data_q [DEPTH];

  logic [TAG_W-1:0]             head_q, tail_q;
  logic [CNT_W-1:0]             count_q, count_d;

  logic alloc, wb, retire;

  // Ready looks only at the registered count, so a full ROB
  // cannot refill in the same cycle it retires.
  assign issue_ready_o = (count_q < CNT_W'(DEPTH));
  assign issue_tag_o   = tail_q;

  assign alloc  = issue_valid_i & issue_ready_o;
  assign wb     = cdb_valid_i & valid_q[cdb_tag_i];
  assign retire = commit_valid_o & commit_ready_i;

  assign commit_valid_o = valid_q[head_q] & done_q[head_q] & ~flush_i;

  always_comb begin
    commit_pc_o     = '0;
    commit_rd_idx_o = '0;
    commit_data_o   = '0;
    commit_except_o = 1'b0;
    if (commit_valid_o) begin
      commit_pc_o     = pc_q[head_q];
      commit_rd_idx_o = rd_q[head_q];
      commit_data_o   = data_q[head_q];
      commit_except_o = except_q[head_q];
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({alloc, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Lookup: a live CDB broadcast wins over the stored entry.
  always_comb begin
    rs1_ready_o = 1'b0;
    rs1_value_o = '0;
    if (cdb_valid_i && cdb_tag_i == rs1_tag_i && valid_q[rs1_tag_i]) begin
      rs1_ready_o = 1'b1;
      rs1_value_o = cdb_data_i;
    end else if (valid_q[rs1_tag_i] && done_q[rs1_tag_i]) begin
      rs1_ready_o = 1'b1;
      rs1_value_o = data_q[rs1_tag_i];
    end
  end

  always_comb begin
    rs2_ready_o = 1'b0;
    rs2_value_o = '0;
    if (cdb_valid_i && cdb_tag_i == rs2_tag_i && valid_q[rs2_tag_i]) begin
      rs2_ready_o = 1'b1;
      rs2_value_o = cdb_data_i;
    end else if (valid_q[rs2_tag_i] && done_q[rs2_tag_i]) begin
      rs2_ready_o = 1'b1;
      rs2_value_o = data_q[rs2_tag_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      done_q   <= '0;
      except_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (wb) begin
        data_q[cdb_tag_i]   <= cdb_data_i;
        except_q[cdb_tag_i] <= cdb_except_i;
        done_q[cdb_tag_i]   <= 1'b1;
      end
      // Tail entry is never valid when alloc fires, so no clash with wb.
      if (alloc) begin
        valid_q[tail_q]  <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        except_q[tail_q] <= 1'b0;
        pc_q[tail_q]     <= issue_pc_i;
        rd_q[tail_q]     <= issue_rd_idx_i;
        tail_q           <= tail_q + TAG_W'(1);
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + TAG_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Testbench for rob: directed vectors, scoreboard queue of
// expected commits checked by an independent commit monitor.
module tb_rob;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [63:0] issue_pc;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        cdb_except;
  logic [3:0]  rs1_tag;
  logic        rs1_ready;
  logic [63:0] rs1_value;
  logic [3:0]  rs2_tag;
  logic        rs2_ready;
  logic [63:0] rs2_value;
  logic        commit_valid;
  logic        commit_ready;
  logic [63:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [63:0] commit_data;
  logic        commit_except;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  int   vecs = 0;
  int   errs = 0;

  rob dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .flush_i        (flush),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .issue_pc_i     (issue_pc),
    .issue_rd_idx_i (issue_rd),
    .issue_tag_o    (issue_tag),
    .cdb_valid_i    (cdb_valid),
    .cdb_tag_i      (cdb_tag),
    .cdb_data_i     (cdb_data),
    .cdb_except_i   (cdb_except),
    .rs1_tag_i      (rs1_tag),
    .rs1_ready_o    (rs1_ready),
    .rs1_value_o    (rs1_value),
    .rs2_tag_i      (rs2_tag),
    .rs2_ready_o    (rs2_ready),
    .rs2_value_o    (rs2_value),
    .commit_valid_o (commit_valid),
    .commit_ready_i (commit_ready),
    .commit_pc_o    (commit_pc),
    .commit_rd_idx_o(commit_rd),
    .commit_data_o  (commit_data),
    .commit_except_o(commit_except)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [4:0] rd,
                      input logic [63:0] data, input logic exc);
    exp_t e;
    e.pc   = pc;
    e.rd   = rd;
    e.data = data;
    e.exc  = exc;
    exp_q.push_back(e);
  endtask

  task automatic cdb(input logic v, input logic [3:0] t,
                     input logic [63:0] d, input logic x);
    cdb_valid  = v;
    cdb_tag    = t;
    cdb_data   = d;
    cdb_except = x;
  endtask

  task automatic alloc(input logic [63:0] pc, input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_pc    = pc;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  // Commit monitor: every accepted retire must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && commit_valid && commit_ready) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL commit_unexpected: got pc 0x%0h expected none",
                   commit_pc);
        end else begin
          e = exp_q.pop_front();
          chk("commit_pc", commit_pc, e.pc);
          chk("commit_rd", 64'(commit_rd), 64'(e.rd));
          chk("commit_data", commit_data, e.data);
          chk("commit_except", 64'(commit_except), 64'(e.exc));
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    issue_valid  = 1'b0;
    issue_pc     = '0;
    issue_rd     = '0;
    commit_ready = 1'b0;
    rs1_tag      = '0;
    rs2_tag      = '0;
    cdb(1'b0, 4'd0, 64'd0, 1'b0);

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_issue_tag", 64'(issue_tag), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_commit_data", commit_data, 64'd0);
    chk("rst_rs1_ready", 64'(rs1_ready), 64'd0);
    chk("rst_rs2_value", rs2_value, 64'd0);

    // Fill all 16 entries
    for (int i = 0; i < 16; i++) begin
      issue_valid = 1'b1;
      issue_pc    = 64'h1000 + 64'(4 * i);
      issue_rd    = 5'(i + 1);
      #1;
      chk("fill_tag", 64'(issue_tag), 64'(i));
      chk("fill_ready", 64'(issue_ready), 64'd1);
      tick();
    end
    issue_pc = 64'h2000;
    issue_rd = 5'd20;
    #1;
    chk("full_ready", 64'(issue_ready), 64'd0);
    chk("full_tag", 64'(issue_tag), 64'd0);
    tick();
    chk("held_ready", 64'(issue_ready), 64'd0);

    // Complete head, retire while full: allocation stalls that cycle
    push(64'h1000, 5'd1, 64'h100, 1'b0);
    commit_ready = 1'b1;
    cdb(1'b1, 4'd0, 64'h100, 1'b0);
    #1;
    chk("no_bypass_commit", 64'(commit_valid), 64'd0);
    tick();
    cdb(1'b0, 4'd0, 64'd0, 1'b0);
    chk("full_commit_valid", 64'(commit_valid), 64'd1);
    chk("full_pop_ready", 64'(issue_ready), 64'd0);
    tick();
    chk("after_pop_ready", 64'(issue_ready), 64'd1);
    chk("after_pop_tag", 64'(issue_tag), 64'd0);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("wrap_tag", 64'(issue_tag), 64'd1);
    chk("wrap_commit_valid", 64'(commit_valid), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush1_tag", 64'(issue_tag), 64'd0);
    chk("flush1_ready", 64'(issue_ready), 64'd1);

    // Out-of-order writeback, in-order commit
    push(64'h3000, 5'd5, 64'hA, 1'b0);
    push(64'h3004, 5'd6, 64'hB, 1'b0);
    push(64'h3008, 5'd7, 64'hC, 1'b0);
    alloc(64'h3000, 5'd5);
    alloc(64'h3004, 5'd6);
    alloc(64'h3008, 5'd7);
    cdb(1'b1, 4'd2, 64'hC, 1'b0);
    tick();
    cdb(1'b1, 4'd0, 64'hA, 1'b0);
    #1;
    chk("ooo_wait", 64'(commit_valid), 64'd0);
    tick();
    cdb(1'b1, 4'd1, 64'hB, 1'b0);
    #1;
    chk("ooo_c0", 64'(commit_valid), 64'd1);
    tick();
    cdb(1'b0, 4'd0, 64'd0, 1'b0);
    #1;
    chk("ooo_c1", 64'(commit_valid), 64'd1);
    tick();
    chk("ooo_c2", 64'(commit_valid), 64'd1);
    tick();
    chk("ooo_empty", 64'(commit_valid), 64'd0);
    chk("ooo_tag", 64'(issue_tag), 64'd3);

    // Lookup bypass and stored value; freed tag ignored
    commit_ready = 1'b0;
    alloc(64'h4000, 5'd8);
    alloc(64'h4004, 5'd9);
    rs1_tag = 4'd3;
    rs2_tag = 4'd4;
    cdb(1'b1, 4'd3, 64'h55, 1'b0);
    #1;
    chk("byp_rs1_ready", 64'(rs1_ready), 64'd1);
    chk("byp_rs1_value", rs1_value, 64'h55);
    chk("byp_rs2_ready", 64'(rs2_ready), 64'd0);
    chk("byp_rs2_value", rs2_value, 64'd0);
    tick();
    cdb(1'b0, 4'd0, 64'd0, 1'b0);
    #1;
    chk("stored_rs1_ready", 64'(rs1_ready), 64'd1);
    chk("stored_rs1_value", rs1_value, 64'h55);
    rs2_tag = 4'd2;
    cdb(1'b1, 4'd2, 64'hDEAD, 1'b0);
    #1;
    chk("freed_byp_ready", 64'(rs2_ready), 64'd0);
    chk("freed_byp_value", rs2_value, 64'd0);
    tick();
    cdb(1'b0, 4'd0, 64'd0, 1'b0);
    #1;
    chk("freed_stored", 64'(rs2_ready), 64'd0);
    push(64'h4000, 5'd8, 64'h55, 1'b0);
    push(64'h4004, 5'd9, 64'h66, 1'b0);
    commit_ready = 1'b1;
    tick();
    cdb(1'b1, 4'd4, 64'h66, 1'b0);
    tick();
    cdb(1'b0, 4'd0, 64'd0, 1'b0);
    tick();
    tick();
    chk("lk_empty", 64'(commit_valid), 64'd0);

    // Exception reported at head, then flushed
    commit_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    alloc(64'h5000, 5'd10);
    alloc(64'h5004, 5'd11);
    cdb(1'b1, 4'd0, 64'h77, 1'b1);
    tick();
    cdb(1'b0, 4'd0, 64'd0, 1'b0);
    #1;
    chk("exc_valid", 64'(commit_valid), 64'd1);
    chk("exc_flag", 64'(commit_except), 64'd1);
    chk("exc_data", commit_data, 64'h77);
    chk("exc_pc", commit_pc, 64'h5000);
    flush        = 1'b1;
    commit_ready = 1'b1;
    issue_valid  = 1'b1;
    issue_pc     = 64'h5008;
    issue_rd     = 5'd12;
    cdb(1'b1, 4'd1, 64'h88, 1'b0);
    #1;
    chk("flush_commit_valid", 64'(commit_valid), 64'd0);
    chk("flush_commit_exc", 64'(commit_except), 64'd0);
    chk("flush_issue_ready", 64'(issue_ready), 64'd1);
    tick();
    flush        = 1'b0;
    issue_valid  = 1'b0;
    commit_ready = 1'b0;
    cdb(1'b0, 4'd0, 64'd0, 1'b0);
    rs1_tag = 4'd1;
    #1;
    chk("post_flush_tag", 64'(issue_tag), 64'd0);
    chk("post_flush_cv", 64'(commit_valid), 64'd0);
    chk("post_flush_rs1", 64'(rs1_ready), 64'd0);

    // Reset with live entries and a concurrent CDB write
    for (int i = 0; i < 5; i++)
      alloc(64'h6000 + 64'(4 * i), 5'(i + 1));
    cdb(1'b1, 4'd0, 64'h1, 1'b0);
    tick();
    cdb(1'b1, 4'd1, 64'h2, 1'b0);
    tick();
    cdb(1'b0, 4'd0, 64'd0, 1'b0);
    #1;
    chk("pre_rst_cv", 64'(commit_valid), 64'd1);
    rst_n       = 1'b0;
    issue_valid = 1'b1;
    cdb(1'b1, 4'd2, 64'h3, 1'b1);
    tick();
    rst_n       = 1'b1;
    issue_valid = 1'b0;
    cdb(1'b0, 4'd0, 64'd0, 1'b0);
    rs1_tag = 4'd2;
    rs2_tag = 4'd0;
    #1;
    chk("rst2_ready", 64'(issue_ready), 64'd1);
    chk("rst2_tag", 64'(issue_tag), 64'd0);
    chk("rst2_cv", 64'(commit_valid), 64'd0);
    chk("rst2_pc", commit_pc, 64'd0);
    chk("rst2_rs1", 64'(rs1_ready), 64'd0);
    chk("rst2_rs2", 64'(rs2_ready), 64'd0);
    chk("rst2_rs2_val", rs2_value, 64'd0);

    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
